// File: rtl/reg_scoreboard.sv
// reg_scoreboard: ID-stage issue scheduler for the register file.
// Tracks outstanding long-latency register writes with per-register
// counters and holds issue on RAW/WAW-saturation hazards or when the
// in-flight limit is reached. A drain sequence lets exception/cache logic
// wait until every tracked write has come back.
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   id_valid / id_ready        ID handshake; issue_fire = id_valid && id_ready
//   reg_read_en_1/2, reg_addr_1/2          source operand decode
//   reg_write_en, reg_write_addr, is_long  destination decode
//   wb_en, wb_addr             long-latency writeback completion
//   flush                      blocks issue for the current cycle
//   drain_req / drain_done     level request / one-cycle completion pulse
//   pending_mask               bit i set while register i has writes pending
//   inflight                   total outstanding tracked writes
//   sb_err                     sticky: writeback to a register with no pending write
module reg_scoreboard #(
    parameter int ADDR_W       = 5,
    parameter int REG_NUM      = 32,
    parameter int CNT_W        = 2,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               id_valid,
    output logic               id_ready,
    output logic               issue_fire,
    input  logic               reg_read_en_1,
    input  logic [ADDR_W-1:0]  reg_addr_1,
    input  logic               reg_read_en_2,
    input  logic [ADDR_W-1:0]  reg_addr_2,
    input  logic               reg_write_en,
    input  logic [ADDR_W-1:0]  reg_write_addr,
    input  logic               is_long,
    input  logic               wb_en,
    input  logic [ADDR_W-1:0]  wb_addr,
    input  logic               flush,
    input  logic               drain_req,
    output logic               drain_done,
    output logic [REG_NUM-1:0] pending_mask,
    output logic [2:0]         inflight,
    output logic               sb_err
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_DONE,
        ST_HOLD
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [2:0]       INFL_MAX = 3'(MAX_INFLIGHT);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_count [REG_NUM];
    logic [2:0]         r_inflight;
    logic               r_sb_err;

    logic               w_raw1;
    logic               w_raw2;
    logic               w_wr_long;
    logic               w_waw_sat;
    logic               w_full;
    logic               w_track;
    logic               w_wb_hit;
    logic               w_wb_err;
    logic [REG_NUM-1:0] w_inc;
    logic [REG_NUM-1:0] w_dec;

    // Hazards look only at registered counts: a writeback in the same cycle
    // does not release a stall, so the dependent issues one cycle later.
    always_comb begin
        w_raw1     = reg_read_en_1 && (reg_addr_1 != '0) && (r_count[reg_addr_1] != '0);
        w_raw2     = reg_read_en_2 && (reg_addr_2 != '0) && (r_count[reg_addr_2] != '0);
        w_wr_long  = reg_write_en && is_long;
        w_waw_sat  = w_wr_long && (r_count[reg_write_addr] == CNT_MAX);
        w_full     = w_wr_long && (reg_write_addr != '0) && (r_inflight == INFL_MAX);
        id_ready   = id_valid && (r_state == ST_RUN) && !flush &&
                     !w_raw1 && !w_raw2 && !w_waw_sat && !w_full;
        issue_fire = id_valid && id_ready;
        w_track    = issue_fire && w_wr_long && (reg_write_addr != '0);
        w_wb_hit   = wb_en && (wb_addr != '0) && (r_count[wb_addr] != '0);
        w_wb_err   = wb_en && (wb_addr != '0) && (r_count[wb_addr] == '0);
    end

    always_comb begin
        w_inc        = '0;
        w_dec        = '0;
        pending_mask = '0;
        for (int unsigned i = 0; i < REG_NUM; i++) begin
            w_inc[i]        = w_track  && (reg_write_addr == ADDR_W'(i));
            w_dec[i]        = w_wb_hit && (wb_addr == ADDR_W'(i));
            pending_mask[i] = (r_count[i] != '0);
        end
    end

    // A track and a writeback on the same register cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < REG_NUM; i++) begin
                r_count[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < REG_NUM; i++) begin
                case ({w_inc[i], w_dec[i]})
                    2'b10:   r_count[i] <= r_count[i] + CNT_W'(1);
                    2'b01:   r_count[i] <= r_count[i] - CNT_W'(1);
                    default: r_count[i] <= r_count[i];
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= '0;
            r_sb_err   <= 1'b0;
        end else begin
            case ({w_track, w_wb_hit})
                2'b10:   r_inflight <= r_inflight + 3'd1;
                2'b01:   r_inflight <= r_inflight - 3'd1;
                default: r_inflight <= r_inflight;
            endcase
            if (w_wb_err) begin
                r_sb_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:   if (drain_req) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (r_inflight == '0) w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = drain_req ? ST_HOLD : ST_RUN;
            ST_HOLD:  if (!drain_req) w_state_nxt = ST_RUN;
            default:  w_state_nxt = ST_RUN;
        endcase
    end

    assign drain_done = (r_state == ST_DONE);
    assign inflight   = r_inflight;
    assign sb_err     = r_sb_err;

endmodule

// File: tb/tb_reg_scoreboard.sv
module tb_reg_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_valid = 1'b0;
    logic        id_ready;
    logic        issue_fire;
    logic        reg_read_en_1 = 1'b0;
    logic [4:0]  reg_addr_1 = '0;
    logic        reg_read_en_2 = 1'b0;
    logic [4:0]  reg_addr_2 = '0;
    logic        reg_write_en = 1'b0;
    logic [4:0]  reg_write_addr = '0;
    logic        is_long = 1'b0;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic        flush = 1'b0;
    logic        drain_req = 1'b0;
    logic        drain_done;
    logic [31:0] pending_mask;
    logic [2:0]  inflight;
    logic        sb_err;

    always #5 clk = ~clk;

    reg_scoreboard #(
        .ADDR_W(5),
        .REG_NUM(32),
        .CNT_W(2),
        .MAX_INFLIGHT(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .id_valid(id_valid),
        .id_ready(id_ready),
        .issue_fire(issue_fire),
        .reg_read_en_1(reg_read_en_1),
        .reg_addr_1(reg_addr_1),
        .reg_read_en_2(reg_read_en_2),
        .reg_addr_2(reg_addr_2),
        .reg_write_en(reg_write_en),
        .reg_write_addr(reg_write_addr),
        .is_long(is_long),
        .wb_en(wb_en),
        .wb_addr(wb_addr),
        .flush(flush),
        .drain_req(drain_req),
        .drain_done(drain_done),
        .pending_mask(pending_mask),
        .inflight(inflight),
        .sb_err(sb_err)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    // Reference model: pending write counts per register, total in flight,
    // sticky error, and drain phase (0 run, 1 draining, 2 done pulse, 3 hold).
    int m_cnt [32];
    int m_infl  = 0;
    bit m_err   = 1'b0;
    int m_phase = 0;

    function automatic bit m_ready();
        if (!id_valid || flush || m_phase != 0) return 1'b0;
        if (reg_read_en_1 && reg_addr_1 != 0 && m_cnt[reg_addr_1] > 0) return 1'b0;
        if (reg_read_en_2 && reg_addr_2 != 0 && m_cnt[reg_addr_2] > 0) return 1'b0;
        if (reg_write_en && is_long && m_cnt[reg_write_addr] == 3) return 1'b0;
        if (reg_write_en && is_long && reg_write_addr != 0 && m_infl == 4) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        bit trk;
        bit hit;
        int old_infl;
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) m_cnt[i] = 0;
            m_infl  = 0;
            m_err   = 1'b0;
            m_phase = 0;
        end else begin
            trk = m_ready() && reg_write_en && is_long && reg_write_addr != 0;
            hit = wb_en && wb_addr != 0 && m_cnt[wb_addr] > 0;
            if (wb_en && wb_addr != 0 && m_cnt[wb_addr] == 0) m_err = 1'b1;
            old_infl = m_infl;
            if (m_phase == 0)      m_phase = drain_req ? 1 : 0;
            else if (m_phase == 1) m_phase = (old_infl == 0) ? 2 : 1;
            else if (m_phase == 2) m_phase = drain_req ? 3 : 0;
            else                   m_phase = drain_req ? 3 : 0;
            if (trk) begin m_cnt[reg_write_addr]++; m_infl++; end
            if (hit) begin m_cnt[wb_addr]--; m_infl--; end
        end
    end

    always @(negedge clk) begin
        logic [31:0] pm;
        pm = '0;
        for (int i = 0; i < 32; i++) if (m_cnt[i] > 0) pm[i] = 1'b1;
        chk("id_ready",     {31'b0, id_ready},   {31'b0, m_ready()});
        chk("issue_fire",   {31'b0, issue_fire}, {31'b0, m_ready()});
        chk("pending_mask", pending_mask,        pm);
        chk("inflight",     {29'b0, inflight},   32'(m_infl));
        chk("sb_err",       {31'b0, sb_err},     {31'b0, m_err});
        chk("drain_done",   {31'b0, drain_done}, {31'b0, (m_phase == 2)});
    end

    task automatic idle();
        id_valid = 0; reg_read_en_1 = 0; reg_addr_1 = '0; reg_read_en_2 = 0; reg_addr_2 = '0;
        reg_write_en = 0; reg_write_addr = '0; is_long = 0; wb_en = 0; wb_addr = '0;
        flush = 0; drain_req = 0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic lw(input int a);
        id_valid = 1; reg_write_en = 1; is_long = 1; reg_write_addr = 5'(a);
    endtask

    initial begin
        int pick;
        idle();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_inflight", {29'b0, inflight}, 0);
        chk("rst_pending",  pending_mask, 0);
        chk("rst_ready",    {31'b0, id_ready}, 0);
        chk("rst_fire",     {31'b0, issue_fire}, 0);
        chk("rst_done",     {31'b0, drain_done}, 0);
        chk("rst_err",      {31'b0, sb_err}, 0);
        rst_n = 1;
        step();

        // 1: RAW on r8, released the cycle after its writeback
        lw(8); #1 chk("t1_issue", {31'b0, id_ready}, 1);
        step(); idle();
        id_valid = 1; reg_read_en_1 = 1; reg_addr_1 = 5'd8;
        #1 chk("t1_inflight", {29'b0, inflight}, 1);
        chk("t1_pending", pending_mask, 32'h100);
        chk("t1_raw", {31'b0, id_ready}, 0);
        step();
        wb_en = 1; wb_addr = 5'd8;
        #1 chk("t1_same_cycle_wb", {31'b0, id_ready}, 0);
        step(); wb_en = 0;
        #1 chk("t1_released", {31'b0, id_ready}, 1);
        chk("t1_pending_clr", pending_mask, 0);
        step(); idle();

        // 2: in-flight limit
        for (int a = 1; a <= 4; a++) begin lw(a); step(); end
        lw(5);
        #1 chk("t2_full", {31'b0, id_ready}, 0);
        chk("t2_inflight4", {29'b0, inflight}, 4);
        wb_en = 1; wb_addr = 5'd2;
        #1 chk("t2_full_wb_cycle", {31'b0, id_ready}, 0);
        step(); wb_en = 0;
        #1 chk("t2_after_wb", {31'b0, id_ready}, 1);
        step(); idle();
        #1 chk("t2_inflight_stays", {29'b0, inflight}, 4);
        chk("t2_pending", pending_mask, 32'h3A);
        wb_en = 1;
        wb_addr = 5'd1; step();
        wb_addr = 5'd3; step();
        wb_addr = 5'd4; step();
        wb_addr = 5'd5; step();
        wb_en = 0;
        #1 chk("t2_drained", {29'b0, inflight}, 0);

        // 3: per-register saturation and simultaneous track+wb
        lw(9); step(); step(); step();
        #1 chk("t3_waw_sat", {31'b0, id_ready}, 0);
        chk("t3_inflight3", {29'b0, inflight}, 3);
        idle(); wb_en = 1; wb_addr = 5'd9; step();
        lw(9);
        #1 chk("t3_track_ok", {31'b0, id_ready}, 1);
        step(); idle();
        #1 chk("t3_net_inflight", {29'b0, inflight}, 2);
        chk("t3_net_pending", pending_mask, 32'h200);
        wb_en = 1; wb_addr = 5'd9; step(); step(); wb_en = 0;
        #1 chk("t3_clear", {29'b0, inflight}, 0);

        // 4: r0 never tracked; stray writeback sets sticky error
        lw(0); reg_read_en_1 = 1; reg_addr_1 = '0; reg_read_en_2 = 1; reg_addr_2 = '0;
        #1 chk("t4_r0_ready", {31'b0, id_ready}, 1);
        step(); step(); idle();
        #1 chk("t4_r0_inflight", {29'b0, inflight}, 0);
        chk("t4_r0_pending", pending_mask, 0);
        wb_en = 1; wb_addr = 5'd7; step(); wb_en = 0;
        #1 chk("t4_err", {31'b0, sb_err}, 1);
        step(); step();
        chk("t4_err_sticky", {31'b0, sb_err}, 1);

        // 5: drain, done pulse, hold, release
        lw(10); step(); lw(11); step(); idle();
        drain_req = 1; step();
        id_valid = 1;
        #1 chk("t5_drain_block", {31'b0, id_ready}, 0);
        wb_en = 1; wb_addr = 5'd10; step();
        wb_addr = 5'd11; step(); wb_en = 0;
        #1 chk("t5_not_yet", {31'b0, drain_done}, 0);
        chk("t5_inflight0", {29'b0, inflight}, 0);
        step();
        chk("t5_done", {31'b0, drain_done}, 1);
        step();
        chk("t5_hold_done", {31'b0, drain_done}, 0);
        chk("t5_hold_block", {31'b0, id_ready}, 0);
        drain_req = 0; step();
        chk("t5_run", {31'b0, id_ready}, 1);
        idle();

        // 6: reset during drain
        lw(12); step(); lw(13); step(); idle();
        drain_req = 1; step();
        #1 chk("t6_inflight2", {29'b0, inflight}, 2);
        rst_n = 0;
        #1 chk("t6_rst_inflight", {29'b0, inflight}, 0);
        chk("t6_rst_pending", pending_mask, 0);
        chk("t6_rst_done", {31'b0, drain_done}, 0);
        step();
        rst_n = 1; drain_req = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t6_no_done", {31'b0, drain_done}, 0);
        end
        id_valid = 1;
        #1 chk("t6_run", {31'b0, id_ready}, 1);
        idle();

        // Randomized traffic over a small register window to provoke hazards
        for (int c = 0; c < 2000; c++) begin
            step();
            id_valid       = ($urandom_range(0, 3) != 0);
            reg_read_en_1  = $urandom_range(0, 1) == 1;
            reg_addr_1     = 5'($urandom_range(0, 7));
            reg_read_en_2  = $urandom_range(0, 1) == 1;
            reg_addr_2     = 5'($urandom_range(0, 7));
            reg_write_en   = $urandom_range(0, 3) != 0;
            reg_write_addr = 5'($urandom_range(0, 7));
            is_long        = $urandom_range(0, 1) == 1;
            flush          = $urandom_range(0, 9) == 0;
            wb_en          = $urandom_range(0, 2) == 0;
            pick           = $urandom_range(0, 7);
            for (int t = 0; t < 8 && m_cnt[pick] == 0; t++) pick = $urandom_range(0, 7);
            wb_addr        = 5'(pick);
            if (!drain_req && $urandom_range(0, 49) == 0) drain_req = 1;
            else if (drain_req && $urandom_range(0, 7) == 0) drain_req = 0;
        end
        idle();
        step(); step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
